uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter FIFO push port among NREQ byte sources, for example the APB write path, a loopback/echo path and a diagnostic pattern source.
- Round-robin arbitration with packet locking: a grant holds until the requester marks its last byte, a burst limit is reached, or the requester stalls past a timeout.
- Drives the transmitter's push/data inputs and tracks FIFO occupancy so it never pushes into a full FIFO.

Parameters:
- NREQ, 4, number of requesters (2..8).
- FIFO_DEPTH, 16, transmitter FIFO depth; matches the 5-bit tx_fifo_count.
- MAX_BURST, 8, maximum bytes per grant before a forced release (1..255).
- HOLD_TIMEOUT, 64, idle PCLK cycles a locked requester may withhold valid before its grant is revoked (1..255).

Ports:
- PCLK  input  1  clock.
- PRESET  input  1  asynchronous, active-high reset.
- arb_en  input  1  when low, no new grants are issued and no bytes are accepted; the current lock is held.
- req_valid  input  NREQ  per-requester byte valid.
- req_last  input  NREQ  per-requester end-of-packet, qualified by req_valid.
- req_data  input  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_ready  output  NREQ  per-requester accept; a byte transfers when valid & ready.
- tx_fifo_count  input  5  occupancy from the transmitter FIFO.
- tx_fifo_full  input  1  full flag from the transmitter FIFO.
- tx_fifo_push  output  1  registered push strobe to the transmitter FIFO.
- tx_fifo_wdata  output  8  registered byte to the transmitter FIFO.
- grant_valid  output  1  high in LOCKED.
- grant_id  output  3  index of the locked requester.
- timeout_err  output  NREQ  sticky per-requester flag, set on a timeout revoke.
- err_clr  input  1  synchronous clear of timeout_err; wins over a same-cycle set.

Behaviour:
- Reset (asynchronous, takes effect immediately; all outputs registered): state=IDLE, rr_ptr=0, grant_valid=0, grant_id=0, tx_fifo_push=0, tx_fifo_wdata=0, timeout_err=0, burst_cnt=0, idle_cnt=0. A push pending at reset is dropped.
- req_ready is combinational: ready[i] = (state==LOCKED) & (grant_id==i) & arb_en & space. Every other bit is 0.
- space = (tx_fifo_count + tx_fifo_push) < FIFO_DEPTH, computed 6 bits wide, and tx_fifo_full==0. This covers the one-cycle lag between a push and the count update.
- Accept in cycle t: tx_fifo_push=1 and tx_fifo_wdata=the accepted byte in cycle t+1, for exactly one cycle. Back-to-back accepts give consecutive push cycles.
- IDLE:
  - If arb_en and any req_valid: pick the first valid index searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Next cycle: LOCKED, grant_id set, burst_cnt=0, idle_cnt=0.
  - Arbitration latency is one cycle; no byte is accepted in IDLE.
- LOCKED:
  - On accept: burst_cnt++, idle_cnt=0.
  - If req_last, or burst_cnt reaches MAX_BURST on this accept: release, state=IDLE, rr_ptr=(grant_id+1) mod NREQ.
  - If req_valid[grant_id]==0: idle_cnt++. A valid byte stalled by FIFO back-pressure or arb_en=0 does not count.
  - idle_cnt==HOLD_TIMEOUT-1 with valid still low: revoke, set timeout_err[grant_id], state=IDLE, rr_ptr advances as on a release.
  - Accept and timeout in the same cycle cannot occur, since accept requires valid.
- A forced release at MAX_BURST does not flag an error. The requester re-arbitrates normally and the packet resumes at its next grant.
- arb_en deasserted while LOCKED: the lock is held, ready=0, idle counting continues only if valid is low.
- Requester inputs changing while ready=0 are ignored. Data is sampled only on the accept cycle.
- FIFO full: ready stays low until space returns; no push is ever issued with count==FIFO_DEPTH.

Test Plan:
1. Reset, then requesters 0 and 2 each send a 3-byte packet (last on byte 3) with the FIFO empty → grant 0 gets bytes 0xA0..0xA2 pushed on consecutive cycles, IDLE, then grant 2 gets 0xC0..0xC2; no interleaving; rr_ptr=3 at the end.
2. All four requesters valid continuously with single-byte packets → grants issue in order 0,1,2,3,0,1; each byte is pushed one cycle after accept.
3. Requester 1 streams 20 bytes with no last, MAX_BURST=8 → release after 8 bytes, other requesters served, requester 1 resumes; timeout_err stays 0.
4. tx_fifo_count=15 with the grant locked → one byte accepted, then ready=0 in the following cycle while tx_fifo_push=1. Count is held at 16 → no further push. Count drops to 15 → ready=1.
5. Requester 3 is granted, sends 1 byte, then drops valid for 64 cycles (HOLD_TIMEOUT=64) → revoke, timeout_err[3]=1, next requester granted. Assert err_clr → flag clears.
6. PRESET asserted mid-packet while tx_fifo_push=1 → push, grant_valid and req_ready drop to 0 immediately (asynchronously). After release, arbitration restarts at requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter FIFO push port among NREQ byte sources.
// A grant locks until end-of-packet, a burst limit, or an idle timeout; pushes are registered.
module uart_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int FIFO_DEPTH   = 16,
    parameter int MAX_BURST    = 8,
    parameter int HOLD_TIMEOUT = 64
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                arb_en,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ-1:0]     req_last,
    input  logic [8*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    input  logic [4:0]          tx_fifo_count,
    input  logic                tx_fifo_full,
    output logic                tx_fifo_push,
    output logic [7:0]          tx_fifo_wdata,
    output logic                grant_valid,
    output logic [2:0]          grant_id,
    output logic [NREQ-1:0]     timeout_err,
    input  logic                err_clr
);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [2:0]      rr_q, rr_d;
    logic [2:0]      gid_q, gid_d;
    logic [7:0]      burst_q, burst_d;
    logic [7:0]      idle_q, idle_d;
    logic            push_q, push_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [NREQ-1:0] err_q, err_d;

    logic [NREQ-1:0] owner_hit;
    logic [7:0]      owner_data [NREQ];
    logic            sel_valid;
    logic            sel_last;
    logic [7:0]      sel_data;
    logic            space;
    logic            accept;
    logic [2:0]      rr_adv;
    logic            pick_found;
    logic [2:0]      pick_idx;

    // One-hot decode of the locked requester avoids indexing narrow vectors with grant_id.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_owner
            assign owner_hit[gi]  = (gid_q == 3'(gi));
            assign owner_data[gi] = owner_hit[gi] ? req_data[8*gi +: 8] : 8'd0;
        end
    endgenerate

    always_comb begin
        sel_data = 8'd0;
        for (int k = 0; k < NREQ; k++) begin
            sel_data = sel_data | owner_data[k];
        end
    end

    assign sel_valid = |(req_valid & owner_hit);
    assign sel_last  = |(req_last & owner_hit);

    // The in-flight push has not reached tx_fifo_count yet, so it is added here.
    assign space  = (({1'b0, tx_fifo_count} + {5'd0, push_q}) < 6'(FIFO_DEPTH)) && !tx_fifo_full;
    assign accept = (state_q == LOCKED) && arb_en && space && sel_valid;
    assign rr_adv = (gid_q == 3'(NREQ - 1)) ? 3'd0 : gid_q + 3'd1;

    always_comb begin
        int idx;
        pick_found = 1'b0;
        pick_idx   = 3'd0;
        idx        = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!pick_found && |(req_valid & (NREQ'(1) << idx))) begin
                pick_found = 1'b1;
                pick_idx   = 3'(idx);
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
            rr_q    <= 3'd0;
            gid_q   <= 3'd0;
            burst_q <= 8'd0;
            idle_q  <= 8'd0;
            push_q  <= 1'b0;
            wdata_q <= 8'd0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gid_q   <= gid_d;
            burst_q <= burst_d;
            idle_q  <= idle_d;
            push_q  <= push_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gid_d   = gid_q;
        burst_d = burst_q;
        idle_d  = idle_q;
        push_d  = accept;
        wdata_d = accept ? sel_data : wdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (arb_en && pick_found) begin
                    state_d = LOCKED;
                    gid_d   = pick_idx;
                    burst_d = 8'd0;
                    idle_d  = 8'd0;
                end
            end
            LOCKED: begin
                if (accept) begin
                    burst_d = burst_q + 8'd1;
                    idle_d  = 8'd0;
                    if (sel_last || burst_q == 8'(MAX_BURST - 1)) begin
                        state_d = IDLE;
                        rr_d    = rr_adv;
                    end
                end else if (!sel_valid) begin
                    if (idle_q == 8'(HOLD_TIMEOUT - 1)) begin
                        state_d = IDLE;
                        rr_d    = rr_adv;
                        err_d   = err_q | owner_hit;
                    end else begin
                        idle_d = idle_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (err_clr) err_d = '0;
    end

    always_comb begin
        req_ready = '0;
        if (state_q == LOCKED && arb_en && space) req_ready = owner_hit;
    end

    assign tx_fifo_push  = push_q;
    assign tx_fifo_wdata = wdata_q;
    assign grant_valid   = (state_q == LOCKED);
    assign grant_id      = gid_q;
    assign timeout_err   = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: a packet-level model of the arbiter and a
// simple FIFO occupancy model predict every output each cycle.
module tb_uart_tx_arbiter;
    localparam int NREQ         = 4;
    localparam int FIFO_DEPTH   = 16;
    localparam int MAX_BURST    = 8;
    localparam int HOLD_TIMEOUT = 64;
    localparam int NPHASE       = 5;
    localparam int PHASE_LEN    = 700;

    logic                PCLK = 1'b0;
    logic                PRESET;
    logic                arb_en;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_last;
    logic [8*NREQ-1:0]   req_data;
    logic [NREQ-1:0]     req_ready;
    logic [4:0]          tx_fifo_count;
    logic                tx_fifo_full;
    logic                tx_fifo_push;
    logic [7:0]          tx_fifo_wdata;
    logic                grant_valid;
    logic [2:0]          grant_id;
    logic [NREQ-1:0]     timeout_err;
    logic                err_clr;

    uart_tx_arbiter #(
        .NREQ(NREQ), .FIFO_DEPTH(FIFO_DEPTH), .MAX_BURST(MAX_BURST), .HOLD_TIMEOUT(HOLD_TIMEOUT)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .arb_en(arb_en),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
        .tx_fifo_count(tx_fifo_count), .tx_fifo_full(tx_fifo_full),
        .tx_fifo_push(tx_fifo_push), .tx_fifo_wdata(tx_fifo_wdata),
        .grant_valid(grant_valid), .grant_id(grant_id),
        .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 PCLK = ~PCLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the port, how long its packet and silence have run.
    bit              owns;
    int              owner;
    int              next_first;
    int              sent_in_grant;
    int              silent_cycles;
    bit              m_push;
    logic [7:0]      m_byte;
    logic [NREQ-1:0] m_err;
    int              fifo_cnt;
    int              fifo_pending;
    int              n_pushes, n_timeouts, n_forced;

    int vp [NPHASE] = '{80, 90, 70, 3, 60};
    int lp [NPHASE] = '{30, 0, 20, 50, 25};
    int dr [NPHASE] = '{90, 100, 20, 50, 60};
    int ae [NPHASE] = '{100, 100, 100, 90, 70};
    int cl [NPHASE] = '{0, 0, 0, 2, 1};

    task automatic model_reset();
        owns = 0; owner = 0; next_first = 0;
        sent_in_grant = 0; silent_cycles = 0;
        m_push = 0; m_byte = 8'd0; m_err = '0;
    endtask

    function automatic bit room();
        return (fifo_cnt + int'(m_push) < FIFO_DEPTH) && (fifo_cnt != FIFO_DEPTH);
    endfunction

    task automatic check_outputs();
        logic [NREQ-1:0] want_ready;
        want_ready = '0;
        if (owns && arb_en && room()) want_ready = NREQ'(1) << owner;
        chk("grant_valid", 32'(grant_valid), 32'(owns));
        if (owns) chk("grant_id", 32'(grant_id), 32'(owner));
        chk("push", 32'(tx_fifo_push), 32'(m_push));
        if (m_push) chk("wdata", 32'(tx_fifo_wdata), 32'(m_byte));
        chk("timeout_err", 32'(timeout_err), 32'(m_err));
        chk("req_ready", 32'(req_ready), 32'(want_ready));
    endtask

    // Advance the model across the coming clock edge using the inputs now applied.
    task automatic model_step(input int ph);
        bit take;
        take = owns && arb_en && room() && req_valid[owner];
        fifo_pending = fifo_cnt + int'(m_push);
        if (fifo_pending > 0 && $urandom_range(0, 99) < dr[ph]) fifo_pending--;
        if (!owns) begin
            if (arb_en && |req_valid) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (!owns && req_valid[(next_first + k) % NREQ]) begin
                        owns = 1; owner = (next_first + k) % NREQ;
                    end
                end
                sent_in_grant = 0; silent_cycles = 0;
            end
        end else if (take) begin
            sent_in_grant++;
            silent_cycles = 0;
            if (req_last[owner] || sent_in_grant == MAX_BURST) begin
                if (!req_last[owner]) n_forced++;
                owns = 0; next_first = (owner + 1) % NREQ;
            end
        end else if (!req_valid[owner]) begin
            silent_cycles++;
            if (silent_cycles == HOLD_TIMEOUT) begin
                owns = 0; next_first = (owner + 1) % NREQ;
                m_err[owner] = 1'b1;
                n_timeouts++;
            end
        end
        m_push = take;
        if (take) begin
            m_byte = req_data[8*owner +: 8];
            n_pushes++;
            $display("push req=%0d data=%02h fifo=%0d", owner, m_byte, fifo_cnt);
        end
        if (err_clr) m_err = '0;
    endtask

    initial begin
        bit rst_done;
        rst_done = 0;
        n_pushes = 0; n_timeouts = 0; n_forced = 0;
        PRESET = 1'b1; arb_en = 1'b0; err_clr = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0;
        fifo_cnt = 0; fifo_pending = 0;
        tx_fifo_count = 5'd0; tx_fifo_full = 1'b0;
        model_reset();
        repeat (3) @(negedge PCLK);
        #1;
        check_outputs();
        chk("reset_grant_id", 32'(grant_id), 32'd0);
        chk("reset_wdata", 32'(tx_fifo_wdata), 32'd0);
        PRESET = 1'b0;

        for (int ph = 0; ph < NPHASE; ph++) begin
            for (int cyc = 0; cyc < PHASE_LEN; cyc++) begin
                @(negedge PCLK);
                PRESET = 1'b0;
                fifo_cnt      = fifo_pending;
                tx_fifo_count = 5'(fifo_cnt);
                tx_fifo_full  = (fifo_cnt == FIFO_DEPTH);
                arb_en  = ($urandom_range(0, 99) < ae[ph]);
                err_clr = ($urandom_range(0, 99) < cl[ph]);
                for (int i = 0; i < NREQ; i++) begin
                    req_valid[i]      = ($urandom_range(0, 99) < vp[ph]);
                    req_last[i]       = ($urandom_range(0, 99) < lp[ph]);
                    req_data[8*i +: 8] = 8'($urandom);
                end
                #1;
                check_outputs();
                if (ph == NPHASE - 1 && !rst_done && m_push && cyc > 100) begin
                    // Asynchronous reset between edges while a push is on the wire.
                    rst_done = 1;
                    #2 PRESET = 1'b1;
                    #1;
                    chk("async_rst_push", 32'(tx_fifo_push), 32'd0);
                    chk("async_rst_grant", 32'(grant_valid), 32'd0);
                    chk("async_rst_ready", 32'(req_ready), 32'd0);
                    chk("async_rst_err", 32'(timeout_err), 32'd0);
                    model_reset();
                    fifo_pending = fifo_cnt;
                end else begin
                    model_step(ph);
                end
            end
        end
        chk("reset_exercised", 32'(rst_done), 32'd1);
        $display("stats: pushes=%0d timeouts=%0d forced_releases=%0d", n_pushes, n_timeouts, n_forced);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
